// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl
//   Fixed-priority interrupt vector controller with one non-maskable line.
//   Maskable channels are either edge- or level-triggered, selected per channel.
//   The lowest-index pending and enabled channel wins. The FSM raises an
//   active-low IRQ, latches the winner's vector on ack, and does not allow
//   nesting until eoi.
//
//   State  | Meaning
//   -------+------------------------------------------------------------
//   IDLE   | no request presented to the CPU (IRQ high)
//   REQ    | IRQ low, waiting for the CPU vector fetch (ack)
//   SERVE  | handler running, vector held, IRQ high until eoi
//
// Ports
//   clk, reset                   clock, async active-high reset
//   irq_src[NUM_CH]              peripheral interrupt requests
//   nmi_src                      non-maskable request (rising edge)
//   mode_wr / mode_wdata         trigger mode write (1=edge, 0=level)
//   mask_wr / mask_wdata         enable mask write (1=enabled)
//   ack, eoi, nmi_ack            CPU handshake pulses
//   IRQ, NMI                     active-low request lines to the CPU
//   vec_addr, vec_id             vector and index of the serviced channel
//   pending                      pending register (debug view)
module irq_vector_ctrl #(
  parameter int                NUM_CH   = 8,
  parameter int                VEC_W    = 16,
  parameter logic [VEC_W-1:0]  BASE_VEC = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] irq_src,
  input  logic              nmi_src,
  input  logic              mode_wr,
  input  logic [NUM_CH-1:0] mode_wdata,
  input  logic              mask_wr,
  input  logic [NUM_CH-1:0] mask_wdata,
  input  logic              ack,
  input  logic              eoi,
  input  logic              nmi_ack,
  output logic              IRQ,
  output logic              NMI,
  output logic [VEC_W-1:0]  vec_addr,
  output logic [3:0]        vec_id,
  output logic [NUM_CH-1:0] pending
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVE} state_t;

  state_t             state_q, state_d;
  logic [NUM_CH-1:0]  pend_q, pend_d;
  logic [NUM_CH-1:0]  prev_q, prev_d;
  logic [NUM_CH-1:0]  mode_q, mode_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [3:0]         vec_id_q, vec_id_d;
  logic [VEC_W-1:0]   vec_addr_q, vec_addr_d;
  logic               irq_q, irq_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic               nmi_pend_q, nmi_pend_d;

  logic [NUM_CH-1:0]  active;
  logic [NUM_CH-1:0]  edge_set;
  logic [NUM_CH-1:0]  ack_clr;
  logic [3:0]         win_id;
  logic               has_active;

  always_comb begin
    active     = pend_q & mask_q;
    has_active = |active;
    edge_set   = irq_src & ~prev_q;

    // Descending scan so the lowest set index is the last assignment.
    win_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (active[i]) win_id = 4'(i);
    end

    state_d    = state_q;
    vec_id_d   = vec_id_q;
    vec_addr_d = vec_addr_q;
    ack_clr    = '0;

    case (state_q)
      ST_IDLE: begin
        if (has_active) state_d = ST_REQ;
      end
      ST_REQ: begin
        // A withdrawn request beats a coincident ack.
        if (!has_active) begin
          state_d = ST_IDLE;
        end else if (ack) begin
          state_d    = ST_SERVE;
          vec_id_d   = win_id;
          vec_addr_d = BASE_VEC + (VEC_W'(win_id) << 1);
          for (int i = 0; i < NUM_CH; i++) ack_clr[i] = (win_id == 4'(i));
        end
      end
      ST_SERVE: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    mask_d = mask_wr ? mask_wdata : mask_q;
    mode_d = mode_wr ? mode_wdata : mode_q;
    prev_d = irq_src;

    for (int i = 0; i < NUM_CH; i++) begin
      if (!mode_d[i]) begin
        pend_d[i] = irq_src[i];                  // level: follows source
      end else if (!mode_q[i]) begin
        pend_d[i] = 1'b0;                        // level->edge: start clean
      end else begin
        pend_d[i] = edge_set[i] | (pend_q[i] & ~ack_clr[i]);
      end
    end

    irq_d = (state_d != ST_REQ);

    nmi_prev_d = nmi_src;
    nmi_pend_d = (nmi_src & ~nmi_prev_q) | (nmi_pend_q & ~nmi_ack);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      prev_q     <= '0;
      mode_q     <= '1;
      mask_q     <= '0;
      vec_id_q   <= '0;
      vec_addr_q <= BASE_VEC;
      irq_q      <= 1'b1;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      prev_q     <= prev_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      vec_id_q   <= vec_id_d;
      vec_addr_q <= vec_addr_d;
      irq_q      <= irq_d;
      nmi_prev_q <= nmi_prev_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign IRQ      = irq_q;
  assign NMI      = ~nmi_pend_q;
  assign vec_addr = vec_addr_q;
  assign vec_id   = vec_id_q;
  assign pending  = pend_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// tb_irq_vector_ctrl
//   Directed bench for irq_vector_ctrl (NUM_CH=8, VEC_W=16, BASE_VEC=FF00).
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_irq_vector_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        nmi_src;
  logic        mode_wr;
  logic [7:0]  mode_wdata;
  logic        mask_wr;
  logic [7:0]  mask_wdata;
  logic        ack;
  logic        eoi;
  logic        nmi_ack;
  logic        IRQ;
  logic        NMI;
  logic [15:0] vec_addr;
  logic [3:0]  vec_id;
  logic [7:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  irq_vector_ctrl #(.NUM_CH(8), .VEC_W(16), .BASE_VEC(16'hFF00)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .nmi_src(nmi_src),
    .mode_wr(mode_wr), .mode_wdata(mode_wdata),
    .mask_wr(mask_wr), .mask_wdata(mask_wdata),
    .ack(ack), .eoi(eoi), .nmi_ack(nmi_ack),
    .IRQ(IRQ), .NMI(NMI), .vec_addr(vec_addr), .vec_id(vec_id), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL reset_irq got %b exp 1", IRQ); end
    n_checks++; if (NMI !== 1'b1) begin n_fail++; $display("FAIL reset_nmi got %b exp 1", NMI); end
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got %h exp 00", pending); end
    n_checks++; if (vec_addr !== 16'hFF00) begin n_fail++; $display("FAIL reset_vec_addr got %h exp FF00", vec_addr); end
    n_checks++; if (vec_id !== 4'd0) begin n_fail++; $display("FAIL reset_vec_id got %0d exp 0", vec_id); end
    reset = 1'b0;
    mask_wr = 1'b1; mask_wdata = 8'hFF; tick(); mask_wr = 1'b0;
  endtask

  task automatic test_single_edge();
    irq_src = 8'h20; tick();
    n_checks++; if (pending !== 8'h20) begin n_fail++; $display("FAIL basic_pend got %h exp 20", pending); end
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL basic_irq_1cyc got %b exp 1", IRQ); end
    irq_src = 8'h00; tick();
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL basic_irq_2cyc got %b exp 0", IRQ); end
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++; if (vec_id !== 4'd5) begin n_fail++; $display("FAIL basic_vec_id got %0d exp 5", vec_id); end
    n_checks++; if (vec_addr !== 16'hFF0A) begin n_fail++; $display("FAIL basic_vec_addr got %h exp FF0A", vec_addr); end
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL basic_pend_clr got %h exp 00", pending); end
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL basic_irq_serve got %b exp 1", IRQ); end
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL basic_irq_idle got %b exp 1", IRQ); end
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++; if (vec_id !== 4'd5) begin n_fail++; $display("FAIL idle_ack_ignored got %0d exp 5", vec_id); end
  endtask

  task automatic test_priority();
    irq_src = 8'h44; tick(); irq_src = 8'h00; tick();
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL prio_irq got %b exp 0", IRQ); end
    ack = 1'b1; tick();
    n_checks++; if (vec_id !== 4'd2) begin n_fail++; $display("FAIL prio_first_id got %0d exp 2", vec_id); end
    n_checks++; if (vec_addr !== 16'hFF04) begin n_fail++; $display("FAIL prio_first_addr got %h exp FF04", vec_addr); end
    n_checks++; if (pending !== 8'h40) begin n_fail++; $display("FAIL prio_pend got %h exp 40", pending); end
    tick(); ack = 1'b0;   // ack while in SERVE must be ignored
    n_checks++; if (vec_id !== 4'd2) begin n_fail++; $display("FAIL serve_ack_ignored got %0d exp 2", vec_id); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL prio_eoi_irq got %b exp 1", IRQ); end
    tick();
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL prio_reassert got %b exp 0", IRQ); end
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++; if (vec_id !== 4'd6) begin n_fail++; $display("FAIL prio_second_id got %0d exp 6", vec_id); end
    n_checks++; if (vec_addr !== 16'hFF0C) begin n_fail++; $display("FAIL prio_second_addr got %h exp FF0C", vec_addr); end
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_level();
    mask_wr = 1'b1; mask_wdata = 8'h08; mode_wr = 1'b1; mode_wdata = 8'hF7; irq_src = 8'h08;
    tick(); mask_wr = 1'b0; mode_wr = 1'b0;
    n_checks++; if (pending !== 8'h08) begin n_fail++; $display("FAIL level_pend got %h exp 08", pending); end
    tick();
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL level_irq got %b exp 0", IRQ); end
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++; if (vec_id !== 4'd3) begin n_fail++; $display("FAIL level_id got %0d exp 3", vec_id); end
    n_checks++; if (vec_addr !== 16'hFF06) begin n_fail++; $display("FAIL level_addr got %h exp FF06", vec_addr); end
    n_checks++; if (pending !== 8'h08) begin n_fail++; $display("FAIL level_pend_kept got %h exp 08", pending); end
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL level_reassert got %b exp 0", IRQ); end
    irq_src = 8'h00; tick();
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL level_pend_drop got %h exp 00", pending); end
    tick();
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL level_withdraw got %b exp 1", IRQ); end
    mode_wr = 1'b1; mode_wdata = 8'hFF; tick(); mode_wr = 1'b0;
  endtask

  task automatic test_mask();
    mask_wr = 1'b1; mask_wdata = 8'h00; tick(); mask_wr = 1'b0;
    irq_src = 8'h02; tick(); irq_src = 8'h00; tick(); tick();
    n_checks++; if (pending !== 8'h02) begin n_fail++; $display("FAIL mask_pend got %h exp 02", pending); end
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL mask_irq_off got %b exp 1", IRQ); end
    mask_wr = 1'b1; mask_wdata = 8'h02; tick(); mask_wr = 1'b0;
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL mask_irq_next got %b exp 1", IRQ); end
    tick();
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL mask_irq_on got %b exp 0", IRQ); end
  endtask

  task automatic test_nmi();
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++; if (vec_id !== 4'd1) begin n_fail++; $display("FAIL nmi_setup_id got %0d exp 1", vec_id); end
    nmi_src = 1'b1; tick(); nmi_src = 1'b0;
    n_checks++; if (NMI !== 1'b0) begin n_fail++; $display("FAIL nmi_low got %b exp 0", NMI); end
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL nmi_irq_unchanged got %b exp 1", IRQ); end
    tick();
    n_checks++; if (NMI !== 1'b0) begin n_fail++; $display("FAIL nmi_held got %b exp 0", NMI); end
    nmi_ack = 1'b1; tick(); nmi_ack = 1'b0;
    n_checks++; if (NMI !== 1'b1) begin n_fail++; $display("FAIL nmi_ack_clr got %b exp 1", NMI); end
    nmi_src = 1'b1; tick(); nmi_src = 1'b0; tick();
    nmi_src = 1'b1; nmi_ack = 1'b1; tick();
    n_checks++; if (NMI !== 1'b0) begin n_fail++; $display("FAIL nmi_set_wins got %b exp 0", NMI); end
    nmi_src = 1'b0; tick(); nmi_ack = 1'b0;
    n_checks++; if (NMI !== 1'b1) begin n_fail++; $display("FAIL nmi_final_clr got %b exp 1", NMI); end
    n_checks++; if (vec_id !== 4'd1) begin n_fail++; $display("FAIL nmi_vec_held got %0d exp 1", vec_id); end
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_set_wins();
    mask_wr = 1'b1; mask_wdata = 8'hFF; tick(); mask_wr = 1'b0;
    irq_src = 8'h04; tick(); irq_src = 8'h00; tick();
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL setwin_irq got %b exp 0", IRQ); end
    irq_src = 8'h04; ack = 1'b1; tick(); irq_src = 8'h00; ack = 1'b0;
    n_checks++; if (vec_id !== 4'd2) begin n_fail++; $display("FAIL setwin_id got %0d exp 2", vec_id); end
    n_checks++; if (pending !== 8'h04) begin n_fail++; $display("FAIL setwin_pend got %h exp 04", pending); end
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL setwin_reassert got %b exp 0", IRQ); end
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL setwin_pend_clr got %h exp 00", pending); end
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_reset_mid_serve();
    irq_src = 8'h10; tick(); irq_src = 8'h00; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++; if (vec_addr !== 16'hFF08) begin n_fail++; $display("FAIL rst_setup_addr got %h exp FF08", vec_addr); end
    irq_src = 8'h10; tick(); irq_src = 8'h00;
    nmi_src = 1'b1; tick(); nmi_src = 1'b0;
    n_checks++; if (pending !== 8'h10) begin n_fail++; $display("FAIL rst_setup_pend got %h exp 10", pending); end
    n_checks++; if (NMI !== 1'b0) begin n_fail++; $display("FAIL rst_setup_nmi got %b exp 0", NMI); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL rst_async_irq got %b exp 1", IRQ); end
    n_checks++; if (NMI !== 1'b1) begin n_fail++; $display("FAIL rst_async_nmi got %b exp 1", NMI); end
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL rst_async_pend got %h exp 00", pending); end
    n_checks++; if (vec_addr !== 16'hFF00) begin n_fail++; $display("FAIL rst_async_addr got %h exp FF00", vec_addr); end
    n_checks++; if (vec_id !== 4'd0) begin n_fail++; $display("FAIL rst_async_id got %0d exp 0", vec_id); end
  endtask

  task automatic test_release_edge();
    irq_src = 8'h01; nmi_src = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (pending !== 8'h01) begin n_fail++; $display("FAIL release_pend got %h exp 01", pending); end
    n_checks++; if (NMI !== 1'b0) begin n_fail++; $display("FAIL release_nmi got %b exp 0", NMI); end
    tick(); tick();
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL release_mask_off got %b exp 1", IRQ); end
    irq_src = 8'h00; nmi_src = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; nmi_src = 1'b0;
    mode_wr = 1'b0; mode_wdata = '0; mask_wr = 1'b0; mask_wdata = '0;
    ack = 1'b0; eoi = 1'b0; nmi_ack = 1'b0;
    test_reset();
    test_single_edge();
    test_priority();
    test_level();
    test_mask();
    test_nmi();
    test_set_wins();
    test_reset_mid_serve();
    test_release_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
